// File: rtl/bus_timer_device.sv
// Memory-mapped 64-bit machine timer (mtime/mtimecmp/level irq) on the device side of the host/device bus.
// Define BUS_TIMER_PRESCALER_EN to build the PRESCALE register and its prescale counter.
module bus_timer_device #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter int DecodeBits   = 5
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    device_req_i,
  input  logic [AddressWidth-1:0] device_addr_i,
  input  logic                    device_we_i,
  input  logic [DataWidth/8-1:0]  device_be_i,
  input  logic [DataWidth-1:0]    device_wdata_i,
  output logic                    device_rvalid_o,
  output logic [DataWidth-1:0]    device_rdata_o,
  output logic                    device_err_o,
  output logic                    timer_irq_o
);

  localparam logic [DecodeBits-1:0] OFF_CTRL   = DecodeBits'(5'h00);
  localparam logic [DecodeBits-1:0] OFF_PRESC  = DecodeBits'(5'h04);
  localparam logic [DecodeBits-1:0] OFF_MT_LO  = DecodeBits'(5'h08);
  localparam logic [DecodeBits-1:0] OFF_MT_HI  = DecodeBits'(5'h0C);
  localparam logic [DecodeBits-1:0] OFF_CMP_LO = DecodeBits'(5'h10);
  localparam logic [DecodeBits-1:0] OFF_CMP_HI = DecodeBits'(5'h14);

  // Replace only the byte lanes whose enable is set.
  function automatic logic [DataWidth-1:0] merge_bytes(
    input logic [DataWidth-1:0]   old_val,
    input logic [DataWidth-1:0]   new_val,
    input logic [DataWidth/8-1:0] be
  );
    logic [DataWidth-1:0] res;
    res = old_val;
    for (int i = 0; i < DataWidth/8; i++) begin
      if (be[i]) begin
        res[i*8 +: 8] = new_val[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = old_val[i*8 +: 8];
      end
    end
    return res;
  endfunction

  logic [DecodeBits-1:0] offset_s;
  logic                  sel_ctrl_s, sel_presc_s, sel_mt_lo_s, sel_mt_hi_s;
  logic                  sel_cmp_lo_s, sel_cmp_hi_s;
  logic                  err_s, wr_s, rd_s, tick_s;
  logic [DataWidth-1:0]  rdata_s, prescale_rd_s;
  logic [63:0]           mtime_inc_s, mtime_nxt_s;
  logic                  en_r;
  logic [63:0]           mtime_r, mtimecmp_r;
  logic                  unused_addr_s;

  assign offset_s      = device_addr_i[DecodeBits-1:0];
  assign unused_addr_s = ^device_addr_i[AddressWidth-1:DecodeBits];

  assign sel_ctrl_s   = (offset_s == OFF_CTRL);
  assign sel_presc_s  = (offset_s == OFF_PRESC);
  assign sel_mt_lo_s  = (offset_s == OFF_MT_LO);
  assign sel_mt_hi_s  = (offset_s == OFF_MT_HI);
  assign sel_cmp_lo_s = (offset_s == OFF_CMP_LO);
  assign sel_cmp_hi_s = (offset_s == OFF_CMP_HI);

  // Anything outside the six word registers (holes or misaligned) is an error.
  assign err_s = !(sel_ctrl_s | sel_presc_s | sel_mt_lo_s | sel_mt_hi_s | sel_cmp_lo_s | sel_cmp_hi_s);
  assign wr_s  = device_req_i & device_we_i & ~err_s;
  assign rd_s  = device_req_i & ~device_we_i & ~err_s;

`ifdef BUS_TIMER_PRESCALER_EN
  logic [31:0] prescale_r;
  logic [31:0] presc_cnt_r;

  assign tick_s        = en_r & (presc_cnt_r == prescale_r);
  assign prescale_rd_s = prescale_r;

  // Prescale register and divider counter; a PRESCALE write restarts the count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prescale_r  <= 32'h0000_0000;
      presc_cnt_r <= 32'h0000_0000;
    end else if (wr_s && sel_presc_s) begin
      prescale_r  <= merge_bytes(prescale_r, device_wdata_i, device_be_i);
      presc_cnt_r <= 32'h0000_0000;
    end else if (tick_s) begin
      presc_cnt_r <= 32'h0000_0000;
    end else if (en_r) begin
      presc_cnt_r <= presc_cnt_r + 32'd1;
    end else begin
      presc_cnt_r <= presc_cnt_r;
    end
  end
`else
  assign tick_s        = en_r;
  assign prescale_rd_s = 32'h0000_0000;
`endif

  // Read mux of register values as they stand in the request cycle.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (offset_s)
      OFF_CTRL:   rdata_s = {31'h0, en_r};
      OFF_PRESC:  rdata_s = prescale_rd_s;
      OFF_MT_LO:  rdata_s = mtime_r[31:0];
      OFF_MT_HI:  rdata_s = mtime_r[63:32];
      OFF_CMP_LO: rdata_s = mtimecmp_r[31:0];
      OFF_CMP_HI: rdata_s = mtimecmp_r[63:32];
      default:    rdata_s = 32'h0000_0000;
    endcase
  end

  // Next mtime: full 64-bit increment first, then a bus write overrides the written half.
  always_comb begin
    mtime_inc_s = mtime_r;
    mtime_nxt_s = mtime_r;
    if (tick_s) begin
      mtime_inc_s = mtime_r + 64'd1;
    end else begin
      mtime_inc_s = mtime_r;
    end
    mtime_nxt_s = mtime_inc_s;
    if (wr_s && sel_mt_lo_s) begin
      mtime_nxt_s[31:0] = merge_bytes(mtime_inc_s[31:0], device_wdata_i, device_be_i);
    end else begin
      mtime_nxt_s[31:0] = mtime_inc_s[31:0];
    end
    if (wr_s && sel_mt_hi_s) begin
      mtime_nxt_s[63:32] = merge_bytes(mtime_inc_s[63:32], device_wdata_i, device_be_i);
    end else begin
      mtime_nxt_s[63:32] = mtime_inc_s[63:32];
    end
  end

  // Timer state: enable, counter and compare value.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      en_r       <= 1'b0;
      mtime_r    <= 64'h0000_0000_0000_0000;
      mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      mtime_r <= mtime_nxt_s;
      if (wr_s && sel_ctrl_s && device_be_i[0]) begin
        en_r <= device_wdata_i[0];
      end
      if (wr_s && sel_cmp_lo_s) begin
        mtimecmp_r[31:0] <= merge_bytes(mtimecmp_r[31:0], device_wdata_i, device_be_i);
      end
      if (wr_s && sel_cmp_hi_s) begin
        mtimecmp_r[63:32] <= merge_bytes(mtimecmp_r[63:32], device_wdata_i, device_be_i);
      end
    end
  end

  // Single-cycle bus response and registered interrupt level.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      device_rvalid_o <= 1'b0;
      device_rdata_o  <= 32'h0000_0000;
      device_err_o    <= 1'b0;
      timer_irq_o     <= 1'b0;
    end else begin
      device_rvalid_o <= device_req_i;
      device_rdata_o  <= rd_s ? rdata_s : 32'h0000_0000;
      device_err_o    <= device_req_i & err_s;
      timer_irq_o     <= (mtime_r >= mtimecmp_r);
    end
  end

endmodule

// File: doc/bus_timer_device.md
Name: bus_timer_device

Overview:
- Memory-mapped machine timer that sits on the device (slave) side of the simple host/device bus and answers requests routed to it by the interconnect.
- Holds a free-running 64-bit mtime counter with an optional prescaler, a 64-bit mtimecmp compare register, and a level interrupt output.
- Responds to every request exactly one cycle later, as the interconnect requires of all devices.

Parameters:
- DataWidth, 32, bus data width; only 32 is supported.
- AddressWidth, 32, bus address width.
- DecodeBits, 5, number of low address bits decoded; all higher bits are ignored.

Ports:
- CLK  input  1  clock.
- RST_N  input  1  reset; one clock, asynchronous assert, active-low.
- device_req_i  input  1  request strobe from the interconnect.
- device_addr_i  input  AddressWidth  byte address.
- device_we_i  input  1  1 = write, 0 = read.
- device_be_i  input  DataWidth/8  byte enables; used on writes only.
- device_wdata_i  input  DataWidth  write data.
- device_rvalid_o  output  1  response valid, one cycle after device_req_i.
- device_rdata_o  output  DataWidth  read data, qualified by device_rvalid_o.
- device_err_o  output  1  error response, qualified by device_rvalid_o.
- timer_irq_o  output  1  level interrupt: mtime >= mtimecmp.

Behaviour:
- Register map, offset = addr[DecodeBits-1:0]:
  - 0x00 CTRL: bit0 EN; other bits read 0 and ignore writes.
  - 0x04 PRESCALE: 32-bit.
  - 0x08 MTIME_LO, 0x0C MTIME_HI.
  - 0x10 MTIMECMP_LO, 0x14 MTIMECMP_HI.
- Reset values:
  - EN=0, PRESCALE=0, presc_cnt=0, mtime=0, mtimecmp=all ones.
  - device_rvalid_o=0, device_rdata_o=0, device_err_o=0, timer_irq_o=0.
- Response timing:
  - Every cycle with device_req_i=1, read or write, produces device_rvalid_o=1 on the next cycle.
  - With no request, device_rvalid_o=0 on the next cycle.
  - No back-pressure; back-to-back requests each get a response.
- Response data:
  - Read: device_rdata_o is the register value sampled in the request cycle, before any same-cycle counter update.
  - Write: device_rdata_o=0.
  - Whenever device_rvalid_o=0, device_rdata_o=0 and device_err_o=0.
- Errors:
  - Triggered by offset 0x18-0x1F or addr[1:0]!=0.
  - Response: device_err_o=1, device_rdata_o=0, no register change.
- Writes:
  - Applied at the clock edge ending the request cycle.
  - Per-byte: byte i is updated only when device_be_i[i]=1.
  - be=0 is a legal no-op and returns err=0.
- Tick generation:
  - When EN=1 and presc_cnt==PRESCALE: tick, presc_cnt<=0.
  - When EN=1 otherwise: presc_cnt<=presc_cnt+1.
  - When EN=0: presc_cnt and mtime hold.
  - PRESCALE=0 gives a tick every cycle.
  - Any write to PRESCALE also clears presc_cnt to 0.
- mtime:
  - Increments by 1 on each tick as a full 64-bit add; carry from LO propagates to HI in the same cycle.
  - Wraps from 0xFFFFFFFF_FFFFFFFF to 0.
- Simultaneous events: a bus write to MTIME_LO or MTIME_HI in a tick cycle wins for the written half.
  - The unwritten half takes its incremented value, carry included.
  - Software must stop the timer (EN=0) before a 64-bit update.
- Interrupt:
  - timer_irq_o is registered: timer_irq_o <= (mtime >= mtimecmp) as an unsigned 64-bit compare of current register values.
  - It therefore lags register changes by one cycle.
  - It is independent of EN and cleared only by raising mtimecmp or lowering mtime.
- Reset mid-operation: asserting RST_N low asynchronously returns all state and outputs to reset values, including a response pending for the next cycle (it is dropped).

Optional Feature:
- Macro: BUS_TIMER_PRESCALER_EN.
- Defined: PRESCALE register and presc_cnt exist as described above.
- Undefined:
  - No prescaler logic; a tick occurs every cycle while EN=1.
  - Offset 0x04 reads 0, ignores writes, and returns err=0.

Test Plan:
- Reset, then read 0x10 and 0x14 -> rvalid=1 one cycle after req, rdata=0xFFFFFFFF each; err=0; timer_irq_o=0.
- Write CTRL=1 with PRESCALE=0, wait 10 cycles, read MTIME_LO -> value within 10-12, rising by exactly 1 per cycle on repeated reads.
- Stop timer, write MTIME_LO=0xFFFFFFFF and MTIME_HI=0, set EN=1, wait 2 ticks -> MTIME_HI=1, MTIME_LO=0x00000000 or 0x00000001.
- Write MTIMECMP_HI=0, MTIMECMP_LO=5, EN=1 -> timer_irq_o rises the cycle after mtime reaches 5; then write MTIMECMP_LO=0xFFFFFFFF -> irq falls one cycle later.
- PRESCALE=3 (macro defined) -> mtime increments once every 4 cycles; macro undefined -> PRESCALE reads 0 and mtime increments every cycle.
- Read at 0x18 and at 0x02, plus a write to 0x08 with be=4'b0010 and wdata=0x0000AB00 -> first two give err=1, rdata=0; the write changes only bits 15:8 of MTIME_LO to 0xAB.
